dmem_mmio: RTL and testbench

- Responder end of the core's M-stage data-memory port.
- Accepts address, write-data and write-enable from the pipelined core.
- Returns read data combinationally in the same cycle, because the core has no memory stall.
- Maps a word RAM plus a small MMIO page: console output FIFO with valid/ready drain port, free-running cycle counter, compare timer with interrupt.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_mmio_cons_fifo.sv | 79 +++++++
 rtl/dmem_mmio.sv | 145 ++++++++++++++
 tb/tb_dmem_mmio.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: MMIO page offsets and register bit positions shared by the
// data-memory responder and its console FIFO.
package dmem_pkg;

    // MMIO register offsets (ALUOutM[7:0])
    localparam logic [7:0] OFF_CONS_DATA  = 8'h00;
    localparam logic [7:0] OFF_CONS_STAT  = 8'h04;
    localparam logic [7:0] OFF_CYCLE      = 8'h08;
    localparam logic [7:0] OFF_TIMER_CMP  = 8'h0C;
    localparam logic [7:0] OFF_TIMER_CTRL = 8'h10;

    // CONS_STAT bit positions
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 4;

    // TIMER_CTRL bit positions
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_PEND = 1;

endpackage

// File: rtl/dmem_mmio_cons_fifo.sv
// cons_fifo: byte-wide console FIFO. Valid/ready drain port, pushes into a
// full FIFO are dropped and latch a sticky overflow flag unless a pop
// happens on the same edge.
module cons_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          clr_ovf_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [7:0]    data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign valid_o = !empty_o;
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign ovf_o   = ovf_q;
    assign count_o = count_q;

    // Next-state: a pop frees a slot for a same-edge push into a full FIFO
    always_comb begin
        pop     = valid_o & ready_i;
        push_ok = push_i & (!full_o | pop);
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (clr_ovf_i)
            ovf_d = 1'b0;
        if (push_i && !push_ok)
            ovf_d = 1'b1;
    end

    // Pointer, count and overflow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Byte storage, not reset (head is masked while empty)
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: M-stage data-memory responder. Word RAM plus MMIO page
// (console FIFO, cycle counter, compare timer). Reads are combinational.
// Optional macro DMEM_TIMER_EN enables TIMER_CMP/TIMER_CTRL and TimerIrq.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        ConsValid,
    output logic [7:0]  ConsData,
    input  logic        ConsReady,
    output logic        TimerIrq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          mmio;
    logic [7:0]    off;
    logic          wr_mmio;
    logic [31:0]   cycle_q, cycle_d;
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic [3:0]    cnt4;
    logic          unused_addr;

    assign mmio        = (ALUOutM[31:16] == MMIO_HI);
    assign off         = ALUOutM[7:0];
    assign ram_idx     = ALUOutM[AW+1:2];
    assign wr_mmio     = MemWriteM & mmio;
    assign cnt4        = 4'(fifo_count);
    assign unused_addr = ^{ALUOutM[15:8], ALUOutM[1:0]};

    cons_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (wr_mmio && off == OFF_CONS_DATA),
        .data_i   (WriteDataM[7:0]),
        .clr_ovf_i(wr_mmio && off == OFF_CONS_STAT && WriteDataM[STAT_OVF]),
        .ready_i  (ConsReady),
        .valid_o  (ConsValid),
        .data_o   (ConsData),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .ovf_o    (fifo_ovf),
        .count_o  (fifo_count)
    );

    // RAM write port; contents are never reset
    always_ff @(posedge clk) begin
        if (MemWriteM && !mmio)
            ram_q[ram_idx] <= WriteDataM;
    end

    // Cycle counter: software load beats the increment
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (wr_mmio && off == OFF_CYCLE)
            cycle_d = WriteDataM;
    end

    // Cycle counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cycle_q <= '0;
        else
            cycle_q <= cycle_d;
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;

    // Timer next-state: a match on the pre-increment count beats a clear
    always_comb begin
        cmp_d  = cmp_q;
        en_d   = en_q;
        pend_d = pend_q;
        if (wr_mmio && off == OFF_TIMER_CMP)
            cmp_d = WriteDataM;
        if (wr_mmio && off == OFF_TIMER_CTRL) begin
            en_d = WriteDataM[CTRL_EN];
            if (WriteDataM[CTRL_PEND])
                pend_d = 1'b0;
        end
        if (en_q && cycle_q == cmp_q)
            pend_d = 1'b1;
    end

    // Timer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_q  <= '0;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            en_q   <= en_d;
            pend_q <= pend_d;
        end
    end

    assign TimerIrq = pend_q & en_q;
`else
    assign TimerIrq = 1'b0;
`endif

    // Combinational read mux: RAM or MMIO page, old values during writes
    always_comb begin
        ReadDataM = '0;
        if (mmio) begin
            case (off)
                OFF_CONS_STAT: begin
                    ReadDataM[STAT_FULL]           = fifo_full;
                    ReadDataM[STAT_EMPTY]          = fifo_empty;
                    ReadDataM[STAT_OVF]            = fifo_ovf;
                    ReadDataM[STAT_CNT_LSB +: 4]   = cnt4;
                end
                OFF_CYCLE:      ReadDataM = cycle_q;
`ifdef DMEM_TIMER_EN
                OFF_TIMER_CMP:  ReadDataM = cmp_q;
                OFF_TIMER_CTRL: begin
                    ReadDataM[CTRL_EN]   = en_q;
                    ReadDataM[CTRL_PEND] = pend_q;
                end
`endif
                default:        ReadDataM = '0;
            endcase
        end else begin
            ReadDataM = ram_q[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio.
// Inputs change at/just after the falling edge; outputs are sampled there.
module tb_dmem_mmio;

    localparam logic [31:0] A_CONS  = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP   = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        ConsValid;
    logic [7:0]  ConsData;
    logic        ConsReady = 1'b0;
    logic        TimerIrq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4), .MMIO_HI(16'hFFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .ConsValid (ConsValid),
        .ConsData  (ConsData),
        .ConsReady (ConsReady),
        .TimerIrq  (TimerIrq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One write cycle; call between a falling edge and the next rising edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ALUOutM    = a;
        WriteDataM = d;
        MemWriteM  = 1'b1;
        @(negedge clk);
        MemWriteM  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemWriteM = 1'b0;
        ALUOutM   = a;
        #1;
        check(tag, ReadDataM, exp);
    endtask

    logic [7:0] full_exp [4];

    initial begin
        full_exp[0] = 8'h32; full_exp[1] = 8'h33;
        full_exp[2] = 8'h34; full_exp[3] = 8'h5A;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_valid", ConsValid, 0);
        check("rst_data", ConsData, 0);
        check("rst_irq", TimerIrq, 0);
        rd("rst_stat", A_STAT, 32'h02);
        rd("rst_cycle", A_CYCLE, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // RAM store/load and aliasing
        wr(32'h10, 32'hDEADBEEF);
        rd("ram_rd", 32'h10, 32'hDEADBEEF);
        rd("ram_alias", 32'h10 + 4 * 64, 32'hDEADBEEF);
        wr(A_CTRL, 32'h0);
        rd("mmio_no_ram_wr", 32'h10, 32'hDEADBEEF);
        wr(32'hFFFF_0014, 32'hAAAA_5555);
        rd("unlisted_rd", 32'hFFFF_0014, 32'h0);
        rd("cons_data_rd", A_CONS, 32'h0);

        // FIFO fill, overflow, drain, ovf clear
        wr(A_CONS, 32'h41);
        #1;
        check("first_valid", ConsValid, 1);
        check("first_data", ConsData, 8'h41);
        wr(A_CONS, 32'h42);
        wr(A_CONS, 32'h43);
        wr(A_CONS, 32'h44);
        rd("stat_full", A_STAT, 32'h41);
        wr(A_CONS, 32'h45);
        rd("stat_ovf", A_STAT, 32'h45);
        ConsReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", ConsValid, 1);
            check("drain_data", ConsData, 32'h41 + i);
            @(negedge clk);
        end
        #1;
        check("drain_done", ConsValid, 0);
        check("drain_done_data", ConsData, 0);
        ConsReady = 1'b0;
        rd("stat_empty_ovf", A_STAT, 32'h06);
        wr(A_STAT, 32'h4);
        rd("stat_ovf_clr", A_STAT, 32'h02);

        // Full FIFO with simultaneous push and pop
        wr(A_CONS, 32'h31);
        wr(A_CONS, 32'h32);
        wr(A_CONS, 32'h33);
        wr(A_CONS, 32'h34);
        ConsReady = 1'b1;
        wr(A_CONS, 32'h5A);
        ConsReady = 1'b0;
        rd("stat_pushpop_full", A_STAT, 32'h41);
        ConsReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("pp_data", ConsData, full_exp[i]);
            @(negedge clk);
        end
        #1;
        check("pp_done", ConsValid, 0);

        // Empty FIFO with push and ready: push only
        wr(A_CONS, 32'h51);
        #1;
        check("empty_pp_valid", ConsValid, 1);
        check("empty_pp_data", ConsData, 8'h51);
        @(negedge clk);
        #1;
        check("empty_pp_popped", ConsValid, 0);
        ConsReady = 1'b0;

        // Cycle counter load and wrap
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd("cyc_load", A_CYCLE, 32'hFFFF_FFFE);
        @(negedge clk);
        rd("cyc_max", A_CYCLE, 32'hFFFF_FFFF);
        @(negedge clk);
        rd("cyc_wrap", A_CYCLE, 32'h0);
        @(negedge clk);
        ALUOutM    = A_CYCLE;
        WriteDataM = 32'h1234;
        MemWriteM  = 1'b1;
        #1;
        check("cyc_rd_old", ReadDataM, 32'h1);
        @(negedge clk);
        MemWriteM = 1'b0;
        rd("cyc_wr_wins", A_CYCLE, 32'h1234);

`ifdef DMEM_TIMER_EN
        // Timer match, clear, and set-beats-clear
        wr(A_CYCLE, 32'h1000);
        wr(A_CMP, 32'h1008);
        rd("cmp_rd", A_CMP, 32'h1008);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 7; i++) begin
            #1;
            check("irq_before_match", TimerIrq, 0);
            @(negedge clk);
        end
        #1;
        check("irq_at_match", TimerIrq, 1);
        rd("ctrl_pend", A_CTRL, 32'h3);
        wr(A_CTRL, 32'h3);
        #1;
        check("irq_cleared", TimerIrq, 0);
        rd("ctrl_after_clr", A_CTRL, 32'h1);
        wr(A_CYCLE, 32'h2000);
        wr(A_CMP, 32'h2003);
        @(negedge clk);
        @(negedge clk);
        wr(A_CTRL, 32'h3);
        #1;
        check("irq_set_beats_clr", TimerIrq, 1);
`else
        // Timer absent: registers read 0, writes ignored
        wr(A_CMP, 32'h5);
        rd("cmp_absent", A_CMP, 32'h0);
        wr(A_CTRL, 32'h3);
        rd("ctrl_absent", A_CTRL, 32'h0);
        check("irq_absent", TimerIrq, 0);
`endif

        // Async reset mid-drain with three bytes queued
        wr(A_CONS, 32'h61);
        wr(A_CONS, 32'h62);
        wr(A_CONS, 32'h63);
        rd("stat_cnt3", A_STAT, 32'h30);
        check("pre_rst_valid", ConsValid, 1);
        ConsReady = 1'b1;
        reset     = 1'b1;
        #1;
        check("arst_valid", ConsValid, 0);
        check("arst_data", ConsData, 0);
        check("arst_irq", TimerIrq, 0);
        rd("arst_stat", A_STAT, 32'h02);
        rd("arst_cycle", A_CYCLE, 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        ConsReady = 1'b0;
        #1;
        check("post_rst_valid", ConsValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
